// File: rtl/mod_load_ctrl.sv
// Byte-serial loader that assembles an AES key or data block into a 256-bit word
// and holds it until the consumer completes a valid/ready handshake.
module mod_load_ctrl #(
  parameter int KEY_BYTES = 32,
  parameter int BLK_BYTES = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         is_key,
  input  logic         abort,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [255:0] out_data,
  output logic         out_is_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [5:0]   byte_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [5:0] KEY_LAST = 6'(KEY_BYTES - 1);
  localparam logic [5:0] BLK_LAST = 6'(BLK_BYTES - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] last_idx;
  logic       accept;
  logic       last_byte;

  // Target length follows the latched type, never the live is_key input.
  assign last_idx  = out_is_key ? KEY_LAST : BLK_LAST;
  assign accept    = (state == LOAD) && in_valid;
  assign last_byte = accept && (byte_cnt == last_idx);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)     state_next = LOAD;
      LOAD:    if (last_byte) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

  // Abort wins over start and byte acceptance, so a byte arriving with abort is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_data   <= '0;
      out_is_key <= 1'b0;
      byte_cnt   <= '0;
    end else if (abort) begin
      out_data <= '0;
      byte_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      out_is_key <= is_key;
      out_data   <= '0;
      byte_cnt   <= '0;
    end else if (accept) begin
      for (int i = 0; i < 32; i++) begin
        if (byte_cnt == 6'(i)) out_data[8*i +: 8] <= in_data;
      end
      byte_cnt <= byte_cnt + 6'd1;
    end
  end

endmodule

// File: tb/tb_mod_load_ctrl.sv
// Scoreboard bench for mod_load_ctrl: directed scenarios plus randomized loads,
// with expected words built by packing the byte list into a 256-bit value.
module tb_mod_load_ctrl;

  logic         clk;
  logic         resetn;
  logic         start;
  logic         is_key;
  logic         abort;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [255:0] out_data;
  logic         out_is_key;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [5:0]   byte_cnt;

  typedef struct {
    logic [255:0] data;
    logic         key;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] load_bytes[32];
  int         tests;
  int         fails;

  mod_load_ctrl #(.KEY_BYTES(32), .BLK_BYTES(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .is_key(is_key), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_data(out_data), .out_is_key(out_is_key), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", out_data, e.data);
        check("sb_key", out_is_key, e.key);
      end
    end
  end

  task automatic fillRandom();
    for (int k = 0; k < 32; k++) load_bytes[k] = 8'($urandom_range(255));
  endtask

  task automatic applyStimulus(input bit key, input int gapPct, input int holdWait,
                               input bit ignStarts, input bit startWithValid);
    int           n;
    int           gaps;
    logic [255:0] exp;
    exp_t         e;
    n   = key ? 32 : 16;
    exp = '0;
    for (int k = 0; k < n; k++) exp[8*k +: 8] = load_bytes[k];
    e.data = exp;
    e.key  = key;
    sb.push_back(e);

    start    = 1'b1;
    is_key   = key;
    in_valid = startWithValid;
    in_data  = 8'hEE;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    is_key   = ~key;
    check("load_busy", busy, 1);
    check("load_in_ready", in_ready, 1);
    check("load_first_cnt", byte_cnt, 0);

    for (int k = 0; k < n; k++) begin
      gaps = 0;
      while (gaps < 3 && $urandom_range(99) < gapPct) begin
        in_valid = 1'b0;
        start    = ignStarts && ($urandom_range(1) == 1);
        @(posedge clk); #1;
        gaps++;
      end
      start = 1'b0;
      check("cnt_progress", byte_cnt, k);
      in_valid = 1'b1;
      in_data  = load_bytes[k];
      if (k == n - 1) check("valid_before_last", out_valid, 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("valid_rise", out_valid, 1);
    check("hold_in_ready", in_ready, 0);
    check("cnt_final", byte_cnt, n);

    repeat (holdWait) begin
      @(posedge clk); #1;
      check("valid_held", out_valid, 1);
      check("data_stable", out_data, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
    check("idle_busy", busy, 0);
    check("data_retained", out_data, exp);
    check("key_retained", out_is_key, key);
  endtask

  task automatic checkOutput(input bit key, input int nBytes, input bit useReset);
    int n;
    n = key ? 32 : 16;
    start  = 1'b1;
    is_key = key;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < nBytes; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(255));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (useReset) begin
      check("pre_reset_valid", out_valid, (nBytes == n));
      resetn = 1'b0;
      abort  = 1'b1;
      @(posedge clk); #1;
      resetn = 1'b1;
      abort  = 1'b0;
      check("reset_key", out_is_key, 0);
    end else begin
      check("pre_abort_cnt", byte_cnt, nBytes);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      abort    = 1'b1;
      start    = 1'b1;
      @(posedge clk); #1;
      abort    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
    end
    check("cancel_busy", busy, 0);
    check("cancel_cnt", byte_cnt, 0);
    check("cancel_data", out_data, 0);
    check("cancel_valid", out_valid, 0);
    check("cancel_in_ready", in_ready, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("no_stray_valid", out_valid, 0);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    resetn    = 1'b0;
    start     = 1'b0;
    is_key    = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", out_data, 0);
    check("rst_key", out_is_key, 0);
    check("rst_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", byte_cnt, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 32; k++) load_bytes[k] = 8'(k);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 32; k++) load_bytes[k] = 8'(8'hA0 + k);
    applyStimulus(1'b1, 30, 5, 1'b0, 1'b0);

    fillRandom();
    applyStimulus(1'b0, 60, 1, 1'b1, 1'b0);

    checkOutput(1'b0, 9, 1'b0);
    fillRandom();
    applyStimulus(1'b0, 20, 0, 1'b0, 1'b0);

    checkOutput(1'b0, 16, 1'b1);

    fillRandom();
    applyStimulus(1'b1, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(3) == 0) begin
        bit key;
        key = 1'($urandom_range(1));
        checkOutput(key, int'($urandom_range(key ? 31 : 15)), 1'b0);
      end else begin
        fillRandom();
        applyStimulus(1'($urandom_range(1)), int'($urandom_range(50)),
                      int'($urandom_range(3)), 1'($urandom_range(1)),
                      1'($urandom_range(1)));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_load_ctrl.md
MOD_LOAD_CTRL -- requirements
Module: mod_load_ctrl

Interface
REQ-001 The block SHALL have parameter KEY_BYTES, default 32, giving the key-load length in bytes (AES-256 key).
REQ-002 The block SHALL have parameter BLK_BYTES, default 16, giving the data-block load length in bytes.
REQ-003 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  input  1  load request; sampled only in IDLE.
REQ-006 The block SHALL have port is_key  input  1  load type, sampled with start: 1 = key, 0 = data block.
REQ-007 The block SHALL have port abort  input  1  cancels any load in progress.
REQ-008 The block SHALL have port in_valid  input  1  in_data holds a valid byte.
REQ-009 The block SHALL have port in_data  input  8  byte stream.
REQ-010 The block SHALL have port in_ready  output  1  block accepts a byte this cycle.
REQ-011 The block SHALL have port out_data  output  256  assembled key or block.
REQ-012 The block SHALL have port out_is_key  output  1  type of out_data.
REQ-013 The block SHALL have port out_valid  output  1  out_data complete and held.
REQ-014 The block SHALL have port out_ready  input  1  consumer takes out_data.
REQ-015 The block SHALL have port busy  output  1  state is not IDLE.
REQ-016 The block SHALL have port byte_cnt  output  6  number of bytes accepted in the current load.

Function
REQ-017 The block SHALL implement states IDLE, LOAD and HOLD.
REQ-018 IDLE: in_ready=0 and out_valid=0; start=1 SHALL latch is_key, clear byte_cnt and clear out_data, then go to LOAD next cycle.
REQ-019 LOAD: in_ready SHALL be 1; a byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-020 The k-th accepted byte (k from 0) SHALL be written to out_data[8k+7:8k], and byte_cnt SHALL increment by 1.
REQ-021 Target length SHALL be KEY_BYTES if the latched type is key, otherwise BLK_BYTES; out_data bits above 8*BLK_BYTES SHALL remain 0 for data loads.
REQ-022 When the byte taking byte_cnt to the target length is accepted, the block SHALL enter HOLD on the next cycle, so out_valid rises exactly 1 cycle after the last byte handshake.
REQ-023 HOLD: in_ready=0; out_valid=1; out_data and out_is_key SHALL be stable until the handshake.
REQ-024 HOLD with out_ready=1 SHALL complete the handshake; the block SHALL return to IDLE next cycle with out_valid=0; out_data SHALL retain its value.
REQ-025 out_valid SHALL NOT drop in HOLD without out_ready, except on abort or reset.
REQ-026 start in LOAD or HOLD SHALL be ignored; is_key SHALL NOT be re-latched.
REQ-027 start and in_valid together in IDLE SHALL NOT accept the byte, because in_ready=0 in IDLE.
REQ-028 abort=1 in any state SHALL force IDLE next cycle, with byte_cnt=0, out_data=0, out_valid=0, in_ready=0.
REQ-029 abort SHALL take priority over start, byte acceptance and the output handshake in the same cycle.
REQ-030 A byte accepted in the same cycle as abort SHALL be discarded.
REQ-031 in_valid=0 in LOAD SHALL hold all state; gaps of any length SHALL be tolerated.
REQ-032 byte_cnt SHALL never exceed the target length; no wrap-around SHALL occur.
REQ-033 busy SHALL be 1 exactly when the state is LOAD or HOLD.

Reset
REQ-034 On a rising clk with resetn=0, the block SHALL enter IDLE.
REQ-035 Reset SHALL set out_data=0, out_is_key=0, out_valid=0, in_ready=0, busy=0 and byte_cnt=0.
REQ-036 Reset SHALL take priority over abort and all other inputs.
REQ-037 Reset asserted mid-LOAD or mid-HOLD SHALL discard the partial or held data; no out_valid SHALL follow.
REQ-038 Outputs SHALL NOT change asynchronously on resetn.

Verification
REQ-039 Data load: start with is_key=0, then bytes 0x00..0x0F back-to-back, out_ready=1 -> out_valid for 1 cycle, 1 cycle after the last byte; out_data[127:0]=0x0F0E..0100, upper 128 bits 0, out_is_key=0.
REQ-040 Key load: start with is_key=1, 32 bytes 0xA0..0xBF, with in_valid gaps and out_ready=0 for 5 cycles -> out_valid held 5 cycles, out_data[7:0]=0xA0, out_data[255:248]=0xBF, out_is_key=1, then IDLE.
REQ-041 Ignored start: start pulses with is_key=1 during a data LOAD -> length stays 16; byte_cnt reaches exactly 16.
REQ-042 Abort: abort asserted with byte_cnt=9 together with a valid byte -> next cycle IDLE, byte_cnt=0, out_data=0; the following start loads cleanly.
REQ-043 Reset mid-HOLD: resetn=0 for 1 cycle while out_valid=1 -> all outputs at reset values the next cycle; out_valid never reasserts without a new load.
REQ-044 Simultaneous start and in_valid in IDLE -> byte not accepted; byte_cnt=0 in the first LOAD cycle.
